// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multicycle control FSM for the RV64 subset datapath
//
// Sequences fetch, decode, execute, memory and writeback for ADD/SUB, ADDI,
// LD, SD, BEQ, BNE and LUI. Build macro: ILLEGAL_OP_TRAP_EN (when defined,
// unknown opcodes trap into ILEGAL and raise excecao until reset).
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   IR6_0, funct7_5      opcode and SUB-select bit from the instruction register
//   zero                 ALU zero flag (used only in BRANCH)
//   PCWrite, IRWrite     PC / instruction register write enables
//   LoadA, LoadB         register-file read latches
//   LoadAluOut, LoadMDR  ALUOut / MDR load enables
//   DMemWrite, RegWrite  data memory / register file write enables
//   ALUSrcA, ALUSrcB     ALU operand selects
//   ALUFct               ALU function (001 ADD, 010 SUB, 000 idle)
//   MemToReg             writeback source select
//   excecao              illegal opcode flag
//   estado               current state code
module unidade_controle (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] IR6_0,
  input  logic       funct7_5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       LoadA,
  output logic       LoadB,
  output logic       LoadAluOut,
  output logic       LoadMDR,
  output logic       DMemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUFct,
  output logic [1:0] MemToReg,
  output logic       excecao,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    BUSCA     = 4'd0,
    ESPERA    = 4'd1,
    DECODE    = 4'd2,
    R_EXEC    = 4'd3,
    ADDI_EXEC = 4'd4,
    WB_ALU    = 4'd5,
    LUI_WB    = 4'd6,
    MEM_ADDR  = 4'd7,
    LD_READ   = 4'd8,
    LD_ESPERA = 4'd9,
    LD_WB     = 4'd10,
    SD_WRITE  = 4'd11,
    BRANCH    = 4'd12,
    ILEGAL    = 4'd13
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_BNE  = 7'b1100111;

  localparam logic [2:0] FCT_IDLE = 3'b000;
  localparam logic [2:0] FCT_ADD  = 3'b001;
  localparam logic [2:0] FCT_SUB  = 3'b010;

  state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BUSCA;
    end else begin
      case (state)
        BUSCA:  state <= ESPERA;
        ESPERA: state <= DECODE;
        DECODE: begin
          case (IR6_0)
            OP_R:           state <= R_EXEC;
            OP_ADDI:        state <= ADDI_EXEC;
            OP_LUI:         state <= LUI_WB;
            OP_LD, OP_SD:   state <= MEM_ADDR;
            OP_BEQ, OP_BNE: state <= BRANCH;
`ifdef ILLEGAL_OP_TRAP_EN
            default:        state <= ILEGAL;
`else
            // Unknown opcode acts as a NOP; the PC was already advanced.
            default:        state <= BUSCA;
`endif
          endcase
        end
        R_EXEC:    state <= WB_ALU;
        ADDI_EXEC: state <= WB_ALU;
        WB_ALU:    state <= BUSCA;
        LUI_WB:    state <= BUSCA;
        MEM_ADDR:  state <= (IR6_0 == OP_LD) ? LD_READ : SD_WRITE;
        LD_READ:   state <= LD_ESPERA;
        LD_ESPERA: state <= LD_WB;
        LD_WB:     state <= BUSCA;
        SD_WRITE:  state <= BUSCA;
        BRANCH:    state <= BUSCA;
`ifdef ILLEGAL_OP_TRAP_EN
        ILEGAL:    state <= ILEGAL;
`endif
        default:   state <= BUSCA;
      endcase
    end
  end

  assign estado = state;

  // Outputs are decoded from the state register rather than registered so
  // that asserting reset kills every write enable within the same cycle and
  // BUSCA outputs are visible in the first cycle after release.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    LoadA      = 1'b0;
    LoadB      = 1'b0;
    LoadAluOut = 1'b0;
    LoadMDR    = 1'b0;
    DMemWrite  = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUFct     = FCT_IDLE;
    MemToReg   = 2'b00;
    excecao    = 1'b0;
    if (!reset) begin
      case (state)
        BUSCA: begin
          ALUSrcB    = 2'b01;
          ALUFct     = FCT_ADD;
          LoadAluOut = 1'b1;
        end
        ESPERA: IRWrite = 1'b1;
        DECODE: begin
          // PC takes PC+4 from ALUOut while ALUOut captures the branch target.
          PCWrite    = 1'b1;
          LoadA      = 1'b1;
          LoadB      = 1'b1;
          ALUSrcB    = 2'b10;
          ALUFct     = FCT_ADD;
          LoadAluOut = 1'b1;
        end
        R_EXEC: begin
          ALUSrcA    = 1'b1;
          ALUFct     = funct7_5 ? FCT_SUB : FCT_ADD;
          LoadAluOut = 1'b1;
        end
        ADDI_EXEC, MEM_ADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUFct     = FCT_ADD;
          LoadAluOut = 1'b1;
        end
        WB_ALU: RegWrite = 1'b1;
        LUI_WB: begin
          RegWrite = 1'b1;
          MemToReg = 2'b10;
        end
        LD_ESPERA: LoadMDR = 1'b1;
        LD_WB: begin
          RegWrite = 1'b1;
          MemToReg = 2'b01;
        end
        SD_WRITE: DMemWrite = 1'b1;
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUFct  = FCT_SUB;
          // Only Mealy term: zero comes from the SUB running this cycle.
          PCWrite = ((IR6_0 == OP_BEQ) && zero) || ((IR6_0 == OP_BNE) && !zero);
        end
`ifdef ILLEGAL_OP_TRAP_EN
        ILEGAL: excecao = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - scoreboard testbench for unidade_controle
module tb_unidade_controle;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] IR6_0 = 7'd0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, IRWrite, LoadA, LoadB, LoadAluOut, LoadMDR;
  logic       DMemWrite, RegWrite, ALUSrcA, excecao;
  logic [1:0] ALUSrcB, MemToReg;
  logic [2:0] ALUFct;
  logic [3:0] estado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [20:0] v;
  } exp_t;

  exp_t sb[$];

  unidade_controle dut (
    .clk(clk), .reset(reset), .IR6_0(IR6_0), .funct7_5(funct7_5), .zero(zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .LoadA(LoadA), .LoadB(LoadB),
    .LoadAluOut(LoadAluOut), .LoadMDR(LoadMDR), .DMemWrite(DMemWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUFct(ALUFct),
    .MemToReg(MemToReg), .excecao(excecao), .estado(estado)
  );

  always #5 clk = ~clk;

  // {estado, PCWrite, IRWrite, LoadA, LoadB, LoadAluOut, LoadMDR, DMemWrite,
  //  RegWrite, ALUSrcA, ALUSrcB, ALUFct, MemToReg, excecao}
  wire [20:0] obs = {estado, PCWrite, IRWrite, LoadA, LoadB, LoadAluOut, LoadMDR,
                     DMemWrite, RegWrite, ALUSrcA, ALUSrcB, ALUFct, MemToReg, excecao};

  task automatic push(input string tag, input logic [3:0] st, input logic [7:0] en,
                      input logic srca, input logic [1:0] srcb, input logic [2:0] fct,
                      input logic [1:0] m2r, input logic exc);
    exp_t e;
    e.tag = tag;
    e.v = {st, en, srca, srcb, fct, m2r, exc};
    sb.push_back(e);
  endtask

  task automatic push_fetch(input string tag);
    push({tag, "_busca"},  4'd0, 8'b0000_1000, 1'b0, 2'b01, 3'b001, 2'b00, 1'b0);
    push({tag, "_espera"}, 4'd1, 8'b0100_0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    push({tag, "_decode"}, 4'd2, 8'b1011_1000, 1'b0, 2'b10, 3'b001, 2'b00, 1'b0);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: observed %h required entry", obs);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
  endtask

  // Entry: just after a falling edge with inputs driven. Checks one entry per
  // cycle mid-low-phase and returns at the falling edge after the last one.
  task automatic drain();
    int n;
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      #1 check_now();
      @(negedge clk);
    end
  endtask

  task automatic start(input logic [6:0] op, input logic f7, input logic z);
    IR6_0 = op;
    funct7_5 = f7;
    zero = z;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    push("reset_state", 4'd0, 8'h00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    #1 check_now();
    @(negedge clk);
    reset = 1'b0;

    // ADDI: 0,1,2,4,5
    start(7'b0010011, 1'b0, 1'b0);
    push_fetch("addi");
    push("addi_exec", 4'd4, 8'b0000_1000, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0);
    push("addi_wb",   4'd5, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    drain();

    // SUB and ADD
    start(7'b0110011, 1'b1, 1'b0);
    push_fetch("sub");
    push("sub_exec", 4'd3, 8'b0000_1000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0);
    push("sub_wb",   4'd5, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    drain();
    start(7'b0110011, 1'b0, 1'b0);
    push_fetch("add");
    push("add_exec", 4'd3, 8'b0000_1000, 1'b1, 2'b00, 3'b001, 2'b00, 1'b0);
    push("add_wb",   4'd5, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    drain();

    // LUI
    start(7'b0110111, 1'b0, 1'b0);
    push_fetch("lui");
    push("lui_wb", 4'd6, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0);
    drain();

    // LD
    start(7'b0000011, 1'b0, 1'b0);
    push_fetch("ld");
    push("ld_addr",   4'd7,  8'b0000_1000, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0);
    push("ld_read",   4'd8,  8'b0000_0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    push("ld_espera", 4'd9,  8'b0000_0100, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    push("ld_wb",     4'd10, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b01, 1'b0);
    drain();

    // SD
    start(7'b0100011, 1'b0, 1'b0);
    push_fetch("sd");
    push("sd_addr",  4'd7,  8'b0000_1000, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0);
    push("sd_write", 4'd11, 8'b0000_0010, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    drain();

    // Branches
    start(7'b1100011, 1'b0, 1'b1);
    push_fetch("beq_t");
    push("beq_taken", 4'd12, 8'b1000_0000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0);
    drain();
    start(7'b1100011, 1'b0, 1'b0);
    push_fetch("beq_nt");
    push("beq_not_taken", 4'd12, 8'b0000_0000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0);
    drain();
    start(7'b1100111, 1'b0, 1'b0);
    push_fetch("bne_t");
    push("bne_taken", 4'd12, 8'b1000_0000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0);
    drain();
    start(7'b1100111, 1'b0, 1'b1);
    push_fetch("bne_nt");
    push("bne_not_taken", 4'd12, 8'b0000_0000, 1'b1, 2'b00, 3'b010, 2'b00, 1'b0);
    drain();

    // Reset asserted mid-LD_WB
    start(7'b0000011, 1'b0, 1'b0);
    push_fetch("ldr");
    push("ldr_addr",   4'd7, 8'b0000_1000, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0);
    push("ldr_read",   4'd8, 8'b0000_0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    push("ldr_espera", 4'd9, 8'b0000_0100, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    drain();
    push("ldr_wb_pre", 4'd10, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b01, 1'b0);
    #1 check_now();
    #1 reset = 1'b1;
    push("ldr_wb_reset", 4'd0, 8'h00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    #1 check_now();
    @(negedge clk);
    reset = 1'b0;
    start(7'b0010011, 1'b0, 1'b0);
    push_fetch("post_reset");
    push("post_reset_exec", 4'd4, 8'b0000_1000, 1'b1, 2'b10, 3'b001, 2'b00, 1'b0);
    push("post_reset_wb",   4'd5, 8'b0000_0001, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    drain();

    // Unknown opcode
    start(7'b1111111, 1'b0, 1'b0);
    push_fetch("ill");
`ifdef ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 12; i++)
      push("ill_trap", 4'd13, 8'h00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1);
`else
    push("ill_nop_busca",  4'd0, 8'b0000_1000, 1'b0, 2'b01, 3'b001, 2'b00, 1'b0);
    push("ill_nop_espera", 4'd1, 8'b0100_0000, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
`endif
    drain();

    reset = 1'b1;
    push("final_reset", 4'd0, 8'h00, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0);
    #1 check_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control FSM for the RV64 subset datapath: ADD/SUB, ADDI, LD, SD, BEQ, BNE, LUI. It sequences the fetch, decode, execute, memory and writeback steps. It drives the write-enables and mux selects for the PC, the instruction register, the A/B/ALUOut/MDR registers, the register file, the ALU and the data memory. It reads only the opcode/funct fields of the instruction register and the ALU `zero` flag; immediates come from the sign-extension unit, which is selected through `ALUSrcB`/`MemToReg`.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; state to BUSCA.
- `IR6_0`  in  7  opcode field of the instruction register.
- `funct7_5`  in  1  bit 30 of the instruction; SUB select for R-type.
- `zero`  in  1  ALU zero flag, combinational from the current ALU operation.
- `PCWrite`  out  1  PC <= ALUOut.
- `IRWrite`  out  1  instruction register <= instruction memory output.
- `LoadA`, `LoadB`  out  1 each  register-file read ports latched.
- `LoadAluOut`  out  1  ALUOut <= ALU result.
- `LoadMDR`  out  1  MDR <= data memory output.
- `DMemWrite`  out  1  data memory write of B at address ALUOut.
- `RegWrite`  out  1  register file write at rd.
- `ALUSrcA`  out  1  0 = PC, 1 = A.
- `ALUSrcB`  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate.
- `ALUFct`  out  3  001 = ADD, 010 = SUB, 000 = idle.
- `MemToReg`  out  2  00 = ALUOut, 01 = MDR, 10 = sign-extension output (LUI).
- `excecao`  out  1  illegal opcode flag.
- `estado`  out  4  current state code, for debug.

## Operation
- Moore FSM. Outputs decode from `estado` only, except `PCWrite` in BRANCH. Any output not listed for a state is 0.
- BUSCA (0): `ALUSrcA`=0, `ALUSrcB`=01, `ALUFct`=ADD, `LoadAluOut`. Instruction memory samples PC at this edge. Next state ESPERA.
- ESPERA (1): `IRWrite`. Next state DECODE.
- DECODE (2): `PCWrite` (PC <= PC+4 held in ALUOut), `LoadA`, `LoadB`, `ALUSrcA`=0, `ALUSrcB`=10, ADD, `LoadAluOut` (branch target = old PC + imm). Next state by `IR6_0`:
  - 0110011 -> R_EXEC (3)
  - 0010011 -> ADDI_EXEC (4)
  - 0110111 -> LUI_WB (6)
  - 0000011, 0100011 -> MEM_ADDR (7)
  - 1100011 (BEQ), 1100111 (BNE) -> BRANCH (12)
  - any other -> see Configuration
- R_EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUFct`=SUB if `funct7_5` else ADD, `LoadAluOut`. Next state WB_ALU (5).
- ADDI_EXEC: `ALUSrcA`=1, `ALUSrcB`=10, ADD, `LoadAluOut`. Next state WB_ALU.
- WB_ALU: `RegWrite`, `MemToReg`=00. Next state BUSCA.
- LUI_WB: `RegWrite`, `MemToReg`=10. Next state BUSCA.
- MEM_ADDR: `ALUSrcA`=1, `ALUSrcB`=10, ADD, `LoadAluOut`. Next state LD_READ (8) if opcode 0000011, else SD_WRITE (11).
- LD_READ -> LD_ESPERA (9), which asserts `LoadMDR` -> LD_WB (10), which asserts `RegWrite` with `MemToReg`=01 -> BUSCA.
- SD_WRITE: `DMemWrite`. Next state BUSCA.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, SUB. `PCWrite` = (BEQ & `zero`) | (BNE & !`zero`). Next state BUSCA.
- Opcode is re-read from the IR in later states; the IR is stable after ESPERA.

## Timing
- Reset: `estado`=0 (BUSCA). While `reset` is high every output is forced to 0; BUSCA outputs appear in the first cycle after deassertion.
- Reset asserted in any state, including mid-store or mid-writeback: the write-enables drop combinationally in the same cycle. No partial writeback completes after assertion.
- CPI: R/ADDI 5, LUI 4, LD 7, SD 5, BEQ/BNE 4 (taken or not).
- `PCWrite` in DECODE and `LoadAluOut` in DECODE coincide. PC takes the old ALUOut (PC+4); ALUOut takes the target on the same edge.
- `zero` is sampled only in BRANCH, during the same cycle as the SUB.

## Configuration
- `ILLEGAL_OP_TRAP_EN` defined: an unknown opcode in DECODE goes to ILEGAL (13). ILEGAL asserts `excecao`=1 and all other outputs 0, and stays there until `reset`.
- `ILLEGAL_OP_TRAP_EN` undefined: an unknown opcode returns from DECODE to BUSCA, acting as a NOP (PC already advanced). `excecao` is tied to 0 and state 13 is unreachable.

## Test plan
- Release reset, then IR = ADDI (0010011) -> `estado` 0,1,2,4,5,0. `PCWrite` only in cycle 3. `RegWrite`=1 only in cycle 5.
- R-type with `funct7_5`=1 -> R_EXEC drives `ALUFct`=010. With `funct7_5`=0 -> 001.
- LD (0000011) -> 7-cycle sequence. `LoadMDR` in state 9. `RegWrite` with `MemToReg`=01 in state 10. SD (0100011) -> `DMemWrite`=1 for exactly one cycle in state 11.
- BEQ with `zero`=1 -> `PCWrite`=1 in BRANCH. BEQ with `zero`=0 -> 0. BNE with `zero`=0 -> 1.
- Opcode 1111111: with the macro -> `estado`=13 and `excecao`=1 held for 10+ cycles. Without the macro -> back to BUSCA, `excecao`=0.
- Assert `reset` during LD_WB -> `RegWrite` drops in the same cycle and `estado`=0. After release, a normal fetch follows.
